// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the shared asynchronous SRAM.
// One access at a time; ties go to the port that was not granted last.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              busy,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sel_q, sel_d;    // 0 = A, 1 = B
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                grant_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_b   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b = b_req && (!a_req || !last_q);
          sel_d   = grant_b;
          last_d  = grant_b;
          we_d    = grant_b ? b_we    : a_we;
          addr_d  = grant_b ? b_addr  : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          cnt_d   = we_d ? WR_LOAD : RD_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          // Sample the SRAM on the last OE-low cycle, before OE is released.
          if (!we_q) begin
            if (sel_q) b_rdata_d = dq_in;
            else       a_rdata_d = dq_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Strobes decode straight from registered state, so they cannot overlap.
  assign Mem_OE   = !((state_q == ACCESS) && !we_q);
  assign Mem_WE   = !((state_q == ACCESS) &&  we_q);
  assign dq_oe    = we_q && ((state_q == ACCESS) || (state_q == RELEASE));
  assign a_ack    = (state_q == RELEASE) && !sel_q;
  assign b_ack    = (state_q == RELEASE) &&  sel_q;
  assign busy     = (state_q != IDLE);
  assign Mem_CE   = 1'b0;
  assign Mem_UB   = 1'b0;
  assign Mem_LB   = 1'b0;
  assign Mem_ADDR = addr_q;
  assign dq_out   = wdata_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-parameter instance with a small
// SRAM model, plus a RD_CYCLES=3 / WR_CYCLES=1 instance for strobe widths.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [19:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic [15:0] a_rdata, b_rdata, dq_out, dq_in;
  logic        a_ack, b_ack, busy, mem_ce, mem_ub, mem_lb, mem_oe, mem_we, dq_oe;
  logic [19:0] mem_addr;

  logic        a2_req, a2_we;
  logic [19:0] a2_addr;
  logic [15:0] a2_wdata, a2_rdata, b2_rdata, dq2_out;
  logic        a2_ack, b2_ack, busy2, ce2, ub2, lb2, oe2, we2, dq2_oe;
  logic [19:0] mem2_addr;
  logic [15:0] dq2_in = 16'hC3C3;

  logic [15:0] mem [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .Clk(clk), .Reset(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .busy(busy), .Mem_CE(mem_ce), .Mem_UB(mem_ub), .Mem_LB(mem_lb),
    .Mem_OE(mem_oe), .Mem_WE(mem_we), .Mem_ADDR(mem_addr),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  sram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(1)) dut2 (
    .Clk(clk), .Reset(rst_n),
    .a_req(a2_req), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_rdata(a2_rdata), .a_ack(a2_ack),
    .b_req(1'b0), .b_we(1'b0), .b_addr(20'h0), .b_wdata(16'h0),
    .b_rdata(b2_rdata), .b_ack(b2_ack),
    .busy(busy2), .Mem_CE(ce2), .Mem_UB(ub2), .Mem_LB(lb2),
    .Mem_OE(oe2), .Mem_WE(we2), .Mem_ADDR(mem2_addr),
    .dq_out(dq2_out), .dq_oe(dq2_oe), .dq_in(dq2_in)
  );

  // Asynchronous SRAM model, indexed by the low address byte.
  assign dq_in = mem[mem_addr[7:0]];
  always @(posedge clk) if (!mem_we) mem[mem_addr[7:0]] <= dq_out;

  typedef struct {
    logic        rst_n, a_req, a_we;
    logic [19:0] a_addr;
    logic        b_req, b_we;
    logic [19:0] b_addr;
    logic [15:0] b_wdata;
    logic [5:0]  e_ctl;     // {oe, we, dq_oe, a_ack, b_ack, busy}
    logic [19:0] e_addr;
    logic [15:0] e_dout, e_ard, e_brd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1234;
    mem[8'h20] = 16'h2222;
    mem[8'h30] = 16'h3333;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    a2_req = 0; a2_we = 0; a2_addr = 0; a2_wdata = 0;
    rst_n = 0;

    //          rst a_rq a_we a_addr      b_rq b_we b_addr      b_wdata     ctl        addr        dout      a_rd      b_rd
    vecs[0]  = '{0, 1, 0, 20'h00010, 0, 0, 20'h00000, 16'h0000, 6'b110000, 20'h00000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{1, 1, 0, 20'h00010, 0, 0, 20'h00000, 16'h0000, 6'b010001, 20'h00010, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{1, 1, 0, 20'h00010, 0, 0, 20'h00000, 16'h0000, 6'b010001, 20'h00010, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{1, 1, 0, 20'h00010, 0, 0, 20'h00000, 16'h0000, 6'b110101, 20'h00010, 16'h0000, 16'h1234, 16'h0000};
    vecs[4]  = '{1, 0, 0, 20'h00010, 0, 0, 20'h00000, 16'h0000, 6'b110000, 20'h00010, 16'h0000, 16'h1234, 16'h0000};
    vecs[5]  = '{1, 0, 0, 20'h00010, 1, 1, 20'h0ABCD, 16'hBEEF, 6'b101001, 20'h0ABCD, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[6]  = '{1, 0, 0, 20'h00010, 1, 1, 20'h0ABCD, 16'hBEEF, 6'b101001, 20'h0ABCD, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[7]  = '{1, 0, 0, 20'h00010, 1, 1, 20'h0ABCD, 16'hBEEF, 6'b111011, 20'h0ABCD, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[8]  = '{1, 0, 0, 20'h00010, 0, 1, 20'h0ABCD, 16'hBEEF, 6'b110000, 20'h0ABCD, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[9]  = '{1, 0, 0, 20'h00010, 1, 0, 20'h0ABCD, 16'h0000, 6'b010001, 20'h0ABCD, 16'h0000, 16'h1234, 16'h0000};
    vecs[10] = '{1, 0, 0, 20'h00010, 1, 0, 20'h0ABCD, 16'h0000, 6'b010001, 20'h0ABCD, 16'h0000, 16'h1234, 16'h0000};
    vecs[11] = '{1, 0, 0, 20'h00010, 1, 0, 20'h0ABCD, 16'h0000, 6'b110011, 20'h0ABCD, 16'h0000, 16'h1234, 16'hBEEF};
    vecs[12] = '{1, 0, 0, 20'h00010, 0, 0, 20'h0ABCD, 16'h0000, 6'b110000, 20'h0ABCD, 16'h0000, 16'h1234, 16'hBEEF};

    // Single reads/writes, including reset with a_req held
    for (int i = 0; i < 13; i++) begin
      rst_n = vecs[i].rst_n;
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr;
      b_wdata = vecs[i].b_wdata;
      step();
      chk($sformatf("v%0d ctl", i), {26'h0, mem_oe, mem_we, dq_oe, a_ack, b_ack, busy}, {26'h0, vecs[i].e_ctl});
      chk($sformatf("v%0d addr", i), {12'h0, mem_addr}, {12'h0, vecs[i].e_addr});
      chk($sformatf("v%0d dout", i), {16'h0, dq_out}, {16'h0, vecs[i].e_dout});
      chk($sformatf("v%0d a_rdata", i), {16'h0, a_rdata}, {16'h0, vecs[i].e_ard});
      chk($sformatf("v%0d b_rdata", i), {16'h0, b_rdata}, {16'h0, vecs[i].e_brd});
    end
    chk("tied_low", {29'h0, mem_ce, mem_ub, mem_lb}, 32'h0);

    // Contention: both held, A wins first tie, then strict alternation
    a_req = 1; a_we = 0; a_addr = 20'h00020;
    b_req = 1; b_we = 0; b_addr = 20'h00030;
    for (int i = 1; i <= 16; i++) begin
      int  ph;
      logic is_b;
      step();
      ph   = (i - 1) % 4;
      is_b = (((i - 1) / 4) % 2) == 1;
      chk($sformatf("cont%0d busy", i), {31'h0, busy}, {31'h0, ph != 3});
      chk($sformatf("cont%0d a_ack", i), {31'h0, a_ack}, {31'h0, (ph == 2) && !is_b});
      chk($sformatf("cont%0d b_ack", i), {31'h0, b_ack}, {31'h0, (ph == 2) && is_b});
      if (ph < 2) begin
        chk($sformatf("cont%0d addr", i), {12'h0, mem_addr}, is_b ? 32'h30 : 32'h20);
        chk($sformatf("cont%0d oe", i), {31'h0, mem_oe}, 32'h0);
      end
      if (ph == 2 && !is_b) chk($sformatf("cont%0d a_rdata", i), {16'h0, a_rdata}, 32'h2222);
      if (ph == 2 &&  is_b) chk($sformatf("cont%0d b_rdata", i), {16'h0, b_rdata}, 32'h3333);
    end
    a_req = 0; b_req = 0;
    step();
    chk("cont idle", {31'h0, busy}, 32'h0);

    // Reset during the second ACCESS cycle of an A write
    a_req = 1; a_we = 1; a_addr = 20'h00040; a_wdata = 16'h5555;
    step();
    chk("rstmid we1", {30'h0, mem_we, dq_oe}, 32'h1);
    step();
    chk("rstmid we2", {30'h0, mem_we, dq_oe}, 32'h1);
    rst_n = 0; a_req = 0;
    step();
    chk("rstmid strobes", {28'h0, mem_we, mem_oe, dq_oe, a_ack}, 32'hC);
    chk("rstmid busy", {31'h0, busy}, 32'h0);
    chk("rstmid rdata", {a_rdata, b_rdata}, 32'h0);
    rst_n = 1;
    step();
    chk("rstmid no ack", {30'h0, a_ack, busy}, 32'h0);

    // Fresh A read after the abandoned write
    a_req = 1; a_we = 0; a_addr = 20'h00010;
    step(); chk("fresh c1 oe", {31'h0, mem_oe}, 32'h0);
    step(); chk("fresh c2 oe", {31'h0, mem_oe}, 32'h0);
    step(); chk("fresh c3 ack", {31'h0, a_ack}, 32'h1);
    chk("fresh rdata", {16'h0, a_rdata}, 32'h1234);
    a_req = 0;
    step(); chk("fresh idle", {31'h0, busy}, 32'h0);

    // RD_CYCLES=3 / WR_CYCLES=1 instance
    a2_req = 1; a2_we = 0; a2_addr = 20'h00077;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) a2_req = 0;
      chk($sformatf("rd3 c%0d oe", i), {31'h0, oe2}, {31'h0, !(i <= 3)});
      chk($sformatf("rd3 c%0d ack", i), {31'h0, a2_ack}, {31'h0, i == 4});
    end
    chk("rd3 rdata", {16'h0, a2_rdata}, 32'hC3C3);
    a2_req = 1; a2_we = 1; a2_addr = 20'h00088; a2_wdata = 16'h0F0F;
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 2) a2_req = 0;
      chk($sformatf("wr1 c%0d we", i), {31'h0, we2}, {31'h0, i != 1});
      chk($sformatf("wr1 c%0d ack", i), {31'h0, a2_ack}, {31'h0, i == 2});
      chk($sformatf("wr1 c%0d dq_oe", i), {31'h0, dq2_oe}, {31'h0, i <= 2});
    end
    chk("wr1 dout", {16'h0, dq2_out}, 32'h0F0F);
    chk("wr1 rdata kept", {16'h0, a2_rdata}, 32'hC3C3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Strobe safety invariants, checked every cycle away from the edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!mem_oe && !mem_we) begin
        errors++;
        $display("FAIL oe_we_overlap: oe=%b we=%b required not both 0", mem_oe, mem_we);
      end
      if (dq_oe && !mem_oe) begin
        errors++;
        $display("FAIL dq_oe_during_read: dq_oe=%b oe=%b required dq_oe=0", dq_oe, mem_oe);
      end
    end
  end

endmodule
